// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC check-node minimum sequencer.
package ldpc_pkg;

  // Pipeline depth of the 8-input minimum unit.
  localparam int MIN_LATENCY = 3;

  typedef enum logic [2:0] {
    StIdle,
    StPass1,
    StDrain1,
    StPass2,
    StDrain2,
    StDone
  } seq_state_e;

endpackage

// File: rtl/ldpc_minimum.sv
// 8-input unsigned minimum tree, three registered stages.
// Ties resolve to the higher lane; location is reported one-hot.
module ldpc_minimum #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]   out_min,
  output logic [7:0]         out_loc
);

  logic [WIDTH-1:0] s1_val [4];
  logic [7:0]       s1_loc [4];
  logic [WIDTH-1:0] s2_val [2];
  logic [7:0]       s2_loc [2];
  logic [WIDTH-1:0] s3_val;
  logic [7:0]       s3_loc;

  // Pairwise compare tree, one level per stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        s1_val[i] <= '1;
        s1_loc[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        s2_val[i] <= '1;
        s2_loc[i] <= '0;
      end
      s3_val <= '1;
      s3_loc <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_data[(2*i+1)*WIDTH +: WIDTH] <= in_data[2*i*WIDTH +: WIDTH]) begin
          s1_val[i] <= in_data[(2*i+1)*WIDTH +: WIDTH];
          s1_loc[i] <= 8'b1 << (2*i+1);
        end else begin
          s1_val[i] <= in_data[2*i*WIDTH +: WIDTH];
          s1_loc[i] <= 8'b1 << (2*i);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (s1_val[2*i+1] <= s1_val[2*i]) begin
          s2_val[i] <= s1_val[2*i+1];
          s2_loc[i] <= s1_loc[2*i+1];
        end else begin
          s2_val[i] <= s1_val[2*i];
          s2_loc[i] <= s1_loc[2*i];
        end
      end
      if (s2_val[1] <= s2_val[0]) begin
        s3_val <= s2_val[1];
        s3_loc <= s2_loc[1];
      end else begin
        s3_val <= s2_val[0];
        s3_loc <= s2_loc[0];
      end
    end
  end

  assign out_min = s3_val;
  assign out_loc = s3_loc;

endmodule

// File: rtl/ldpc_min_sequencer.sv
// Two-pass min1/min2 search over one check-node row using a shared 8-input min unit.
module ldpc_min_sequencer
  import ldpc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MAX_DEG = 32,
  localparam int NCHUNK = MAX_DEG / 8,
  localparam int IDXW   = $clog2(MAX_DEG)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [IDXW:0]            i_degree,
  input  logic [MAX_DEG*WIDTH-1:0] i_row_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [WIDTH-1:0]         o_min1,
  output logic [WIDTH-1:0]         o_min2,
  output logic [IDXW-1:0]          o_min1_index
);

  // Counter wide enough for both chunk count and drain length.
  localparam int CW = ($clog2(NCHUNK + 1) > 2) ? $clog2(NCHUNK + 1) : 2;
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(MIN_LATENCY - 1);
  localparam logic [IDXW:0] DEG_ONE    = 1;

  seq_state_e               state_q;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            last_chunk_q;
  logic [CW-1:0]            ret_q;
  logic [MAX_DEG*WIDTH-1:0] row_q;
  logic [MIN_LATENCY-1:0]   vld_q;
  logic [WIDTH-1:0]         run_min1;
  logic [WIDTH-1:0]         run_min2;
  logic [IDXW-1:0]          run_idx;

  logic [8*WIDTH-1:0]       mu_in;
  logic [WIDTH-1:0]         mu_min;
  logic [7:0]               mu_loc;
  logic [2:0]               enc;
  logic [CW+2:0]            gidx_wide;
  logic [IDXW-1:0]          gidx;
  logic [IDXW:0]            deg_m1;
  logic                     deg_bad;
  logic                     issue;
  int                       lane;

  assign issue   = (state_q == StPass1) || (state_q == StPass2);
  assign deg_bad = (i_degree == '0) || (int'(i_degree) > MAX_DEG);
  assign deg_m1  = i_degree - DEG_ONE;

  // Select the current chunk; second pass hides the min1 lane.
  always_comb begin
    mu_in = '1;
    lane  = 0;
    if (issue) begin
      for (int k = 0; k < 8; k++) begin
        lane = int'(cnt_q) * 8 + k;
        if (!(state_q == StPass2 && lane == int'(run_idx))) begin
          mu_in[k*WIDTH +: WIDTH] = row_q[lane*WIDTH +: WIDTH];
        end
      end
    end
  end

  // One-hot location to lane number, then prepend the returning chunk number.
  always_comb begin
    enc = '0;
    for (int k = 0; k < 8; k++) begin
      if (mu_loc[k]) enc = enc | 3'(k);
    end
    gidx_wide = {ret_q, enc};
    gidx      = gidx_wide[IDXW-1:0];
  end

  ldpc_minimum #(
    .WIDTH(WIDTH)
  ) u_min (
    .clock  (i_clock),
    .reset  (i_reset),
    .in_data(mu_in),
    .out_min(mu_min),
    .out_loc(mu_loc)
  );

  // Sequencer FSM, running compare and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_chunk_q <= '0;
      ret_q        <= '0;
      row_q        <= '1;
      vld_q        <= '0;
      run_min1     <= '1;
      run_min2     <= '1;
      run_idx      <= '1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_min1       <= '0;
      o_min2       <= '0;
      o_min1_index <= '0;
    end else begin
      vld_q   <= {vld_q[MIN_LATENCY-2:0], issue};
      o_done  <= 1'b0;
      o_error <= 1'b0;
      if (o_done) o_busy <= 1'b0;

      // Strictly-less update keeps the earlier chunk on ties.
      if (vld_q[MIN_LATENCY-1]) begin
        ret_q <= ret_q + CNT_ONE;
        if (state_q == StPass1 || state_q == StDrain1) begin
          if (mu_min < run_min1) begin
            run_min1 <= mu_min;
            run_idx  <= gidx;
          end
        end else if (state_q == StPass2 || state_q == StDrain2) begin
          if (mu_min < run_min2) run_min2 <= mu_min;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (i_start && !o_busy) begin
            if (deg_bad) begin
              o_error <= 1'b1;
            end else begin
              for (int k = 0; k < MAX_DEG; k++) begin
                row_q[k*WIDTH +: WIDTH] <= (k < int'(i_degree)) ?
                                           i_row_data[k*WIDTH +: WIDTH] : '1;
              end
              last_chunk_q <= CW'(deg_m1 >> 3);
              cnt_q        <= '0;
              ret_q        <= '0;
              run_min1     <= '1;
              run_min2     <= '1;
              run_idx      <= '1;
              o_busy       <= 1'b1;
              state_q      <= StPass1;
            end
          end
        end
        StPass1, StPass2: begin
          if (cnt_q == last_chunk_q) begin
            cnt_q   <= '0;
            state_q <= (state_q == StPass1) ? StDrain1 : StDrain2;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        StDrain1, StDrain2: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q   <= '0;
            ret_q   <= '0;
            state_q <= (state_q == StDrain1) ? StPass2 : StDone;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        StDone: begin
          o_min1       <= run_min1;
          o_min2       <= run_min2;
          o_min1_index <= run_idx;
          o_done       <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_min_sequencer.sv
// Directed bench for ldpc_min_sequencer: vector table plus multi-cycle corner sequences.
module tb_ldpc_min_sequencer;

  localparam int W  = 16;
  localparam int MD = 32;
  localparam int IW = 5;

  typedef logic [MD*W-1:0] row_t;

  typedef struct {
    string        name;
    int           deg;
    row_t         data;
    logic [W-1:0] min1;
    int           idx;
    logic [W-1:0] min2;
    int           lat;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW:0]   degree;
  row_t          row_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  min1;
  logic [W-1:0]  min2;
  logic [IW-1:0] min1_index;

  int   errors;
  int   checks;
  vec_t vecs[7];

  ldpc_min_sequencer #(
    .WIDTH  (W),
    .MAX_DEG(MD)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_degree    (degree),
    .i_row_data  (row_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (err),
    .o_min1      (min1),
    .o_min2      (min2),
    .o_min1_index(min1_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic row_t fill(input logic [W-1:0] v);
    row_t r;
    for (int k = 0; k < MD; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Start a row, optionally inject an extra start mid-row, and check the result.
  task automatic run_row(input vec_t v, input int intrude_at, input row_t alt);
    int lat;
    bit got;
    bit err_seen;
    start    = 1'b1;
    degree   = (IW+1)'(v.deg);
    row_data = v.data;
    @(negedge clk);
    start    = 1'b0;
    degree   = '0;
    row_data = '0;
    check({v.name, " busy_after_accept"}, 32'(busy), 32'd1);
    lat      = 0;
    got      = 1'b0;
    err_seen = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (err) err_seen = 1'b1;
      if (done) begin
        got = 1'b1;
      end else if (lat == intrude_at) begin
        start    = 1'b1;
        degree   = (IW+1)'(MD);
        row_data = alt;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({v.name, " done_seen"}, 32'(got), 32'd1);
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " min1"}, 32'(min1), 32'(v.min1));
    check({v.name, " min1_index"}, 32'(min1_index), 32'(v.idx));
    check({v.name, " min2"}, 32'(min2), 32'(v.min2));
    check({v.name, " busy_in_done"}, 32'(busy), 32'd1);
    check({v.name, " no_error"}, 32'(err_seen), 32'd0);
    @(negedge clk);
    check({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    check({v.name, " busy_cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    row_t d;
    row_t alt;
    bit   any_done;
    bit   any_busy;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    degree   = '0;
    row_data = '0;

    d = fill(16'd0);
    for (int k = 0; k < MD; k++) d[k*W +: W] = 16'(100 + k);
    d[19*W +: W] = 16'd5;
    d[3*W +: W]  = 16'd7;
    vecs[0] = '{"deg32", 32, d, 16'd5, 19, 16'd7, 15};

    d = fill(16'd0);
    for (int k = 0; k < 16; k++) d[k*W +: W] = 16'd42;
    vecs[1] = '{"deg16_equal", 16, d, 16'd42, 7, 16'd42, 11};

    d = fill(16'd0);
    d[0 +: W] = 16'd9;
    vecs[2] = '{"deg1", 1, d, 16'd9, 0, 16'hFFFF, 9};

    d = fill(16'd0);
    for (int k = 0; k < 5; k++) d[k*W +: W] = 16'(50 - 10 * k);
    vecs[3] = '{"deg5_pad", 5, d, 16'd10, 4, 16'd20, 9};

    d = fill(16'd0);
    for (int k = 0; k < 8; k++) d[k*W +: W] = 16'(200 + k);
    d[8*W +: W] = 16'd1;
    vecs[4] = '{"deg9_chunk1", 9, d, 16'd1, 8, 16'd200, 11};

    d = fill(16'd0);
    for (int k = 0; k < 24; k++) d[k*W +: W] = 16'hFFFE;
    d[23*W +: W] = 16'd0;
    vecs[5] = '{"deg24_pad", 24, d, 16'd0, 23, 16'hFFFE, 13};

    d = fill(16'd500);
    d[2*W +: W]  = 16'd3;
    d[20*W +: W] = 16'd3;
    vecs[6] = '{"deg32_xtie", 32, d, 16'd3, 2, 16'd3, 15};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(err), 32'd0);
    check("reset min1", 32'(min1), 32'd0);
    check("reset min2", 32'(min2), 32'd0);
    check("reset index", 32'(min1_index), 32'd0);

    // Rows back to back: each start lands on the cycle after o_done.
    for (int i = 0; i < 7; i++) run_row(vecs[i], 0, '0);

    // Illegal degrees: error pulse only, outputs hold the previous row.
    start  = 1'b1;
    degree = '0;
    @(negedge clk);
    start = 1'b0;
    check("deg0 error_pulse", 32'(err), 32'd1);
    check("deg0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("deg0 error_clear", 32'(err), 32'd0);
    start  = 1'b1;
    degree = 6'd33;
    @(negedge clk);
    start = 1'b0;
    check("deg33 error_pulse", 32'(err), 32'd1);
    check("deg33 busy", 32'(busy), 32'd0);
    any_done = 1'b0;
    any_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
      if (busy) any_busy = 1'b1;
    end
    check("illegal no_done", 32'(any_done), 32'd0);
    check("illegal no_busy", 32'(any_busy), 32'd0);
    check("hold min1", 32'(min1), 32'd3);
    check("hold index", 32'(min1_index), 32'd2);
    check("hold min2", 32'(min2), 32'd3);

    // Second start at cycle 4 carries different data and must be ignored.
    alt = fill(16'd1);
    run_row(vecs[0], 3, alt);

    // Reset at cycle 6 of a row aborts it with no o_done.
    start    = 1'b1;
    degree   = 6'd32;
    row_data = vecs[6].data;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort min1", 32'(min1), 32'd0);
    check("abort min2", 32'(min2), 32'd0);
    check("abort index", 32'(min1_index), 32'd0);
    any_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("abort no_done", 32'(any_done), 32'd0);

    // Start in the first cycle after reset release is accepted.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_row(vecs[4], 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_min_sequencer.md
LDPC_MIN_SEQUENCER -- requirements
Module: ldpc_min_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: magnitude width of each check-node message; comparisons are unsigned.
REQ-002 Parameter MAX_DEG, default 32: maximum row degree; SHALL be a multiple of 8.
REQ-003 Derived constant NCHUNK = MAX_DEG/8; IDXW = clog2(MAX_DEG).
REQ-004 i_clock  in  1  sole clock; all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  single-cycle request to process one row.
REQ-007 i_degree  in  IDXW+1  row degree, valid range 1..MAX_DEG; sampled with i_start.
REQ-008 i_row_data  in  MAX_DEG*WIDTH  messages, lane k at bits [k*WIDTH +: WIDTH]; sampled with i_start.
REQ-009 o_busy  out  1  high from the cycle after accept through the o_done cycle.
REQ-010 o_done  out  1  one-cycle pulse: results valid.
REQ-011 o_error  out  1  one-cycle pulse: start rejected for illegal degree.
REQ-012 o_min1  out  WIDTH  smallest message in row.
REQ-013 o_min2  out  WIDTH  second smallest message (min1 lane excluded).
REQ-014 o_min1_index  out  IDXW  lane index of o_min1.

Function
REQ-015 i_start in IDLE with legal degree SHALL capture i_degree and i_row_data into internal registers; later input changes SHALL NOT affect the result.
REQ-016 i_start while o_busy SHALL be ignored, with no error.
REQ-017 i_start in IDLE with degree 0 or degree > MAX_DEG SHALL pulse o_error on the next cycle and remain in IDLE.
REQ-018 Lanes >= degree SHALL be padded with all-ones before use.
REQ-019 FSM states: IDLE, PASS1, DRAIN1, PASS2, DRAIN2, DONE.
REQ-020 IDLE->PASS1 on legal start. PASS1 issues chunks 0..n-1 (n = ceil(degree/8)), one per cycle, to the 8-input min unit. PASS1->DRAIN1 after the last issue.
REQ-021 DRAIN1 SHALL last 3 cycles, matching min-unit latency. The running min1/index updates each cycle a result returns.
REQ-022 Running compare: a returned chunk minimum replaces the stored value only if strictly less. On a cross-chunk tie the earlier chunk is kept.
REQ-023 Global index = chunk*8 + one-hot-to-binary of the min unit's location vector.
REQ-024 PASS2 SHALL re-issue chunks 0..n-1 with lane min1_index forced to all-ones. DRAIN2 SHALL then last 3 cycles, with running min2 kept the same way.
REQ-025 DONE SHALL last one cycle: o_done=1 and outputs updated, then return to IDLE.
REQ-026 Latency from the accept edge to o_done high SHALL be exactly 2n+7 cycles.
REQ-027 Degree 1: o_min2 SHALL equal all-ones.
REQ-028 Outputs SHALL hold their last values until the next o_done.
REQ-029 The min-unit input SHALL be all-ones on cycles with no issue.

Reset
REQ-030 i_reset SHALL force IDLE and clear o_busy, o_done, o_error, o_min1, o_min2 and o_min1_index to 0. Internal running registers SHALL be set to all-ones.
REQ-031 Reset mid-operation SHALL abort the row. No o_done SHALL follow. A start in the first cycle after reset release SHALL be accepted.
REQ-032 Reset SHALL propagate to the min-unit instance. In-flight pipeline results SHALL be discarded via a cleared valid shift register.

Structure
REQ-033 Shared package ldpc_pkg SHALL hold the FSM state enum and the min-unit latency constant (3).
REQ-034 The block SHALL instantiate exactly one ldpc_minimum (WIDTH passed through), plus a local 3-bit issue-valid shift register and a chunk counter.
REQ-035 Only the running-compare registers, the index encoder and the FSM SHALL be added.

Verification
REQ-036 deg=32, lane k = 100+k except lane 19 = 5 and lane 3 = 7 -> min1=5, index=19, min2=7, done at cycle 2*4+7=15.
REQ-037 deg=16, all lanes = 42 -> min1=42, index=7 (highest lane in chunk 0), min2=42.
REQ-038 deg=1, lane0 = 9, other lanes = 0 -> min1=9, index=0, min2=16'hFFFF, latency 9.
REQ-039 deg=0, then deg=33 -> o_error pulses after each; o_busy stays 0, no o_done.
REQ-040 Start; second start with different data at cycle 4; reset at cycle 6 of a third row -> second start ignored, first result correct, third row yields no o_done, outputs zero.
REQ-041 Back-to-back rows, each start on the cycle after o_done -> each accepted, results independent.
